// File: rtl/fpa_sched_pkg.sv
// Shared constants and tag type for the fpa_sched adder-sharing block.
package fpa_sched_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned SIGN_BIT = 31;

    // Tag id is sized for the largest supported requester count.
    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned TAG_ID_W = $clog2(NREQ_MAX);

    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fpa_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr wins, otherwise lowest index wraps around.
module fpa_sched_rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic             hi_found;
    logic             lo_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // Descending scan so the lowest qualifying index is the last one written.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
            end
        end
    end

    assign any = hi_found | lo_found;
    assign idx = hi_found ? hi_idx : lo_idx;

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = any && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/fpa_sched.sv
// Shares one fixed-latency FP adder between NREQ requesters with a tag pipeline for routing.
// Optional macro FPA_SUB_EN: req_sub flips operand B's sign on issue (A - B).
module fpa_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned FPA_LAT = 2,
    parameter int unsigned FP_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    input  logic [NREQ-1:0]      req_sub,
    output logic [FP_W-1:0]      fpa_a,
    output logic [FP_W-1:0]      fpa_b,
    input  logic [FP_W-1:0]      fpa_c,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]      rsp_data,
    output logic                 busy
);

    import fpa_sched_pkg::*;

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned NSTG  = FPA_LAT + 1;

    logic [NREQ-1:0]  pending_q;
    logic [NREQ-1:0]  pending_d;
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done_oh;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] gnt_idx;
    logic             issue;
    logic [FP_W-1:0]  op_a;
    logic [FP_W-1:0]  op_b;
    logic [FP_W-1:0]  op_b_eff;
    logic             op_sub;
    tag_t             tag_q [NSTG];
    tag_t             tag_in;
    tag_t             tag_out;

    assign elig = req_valid & ~pending_q;

    fpa_sched_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req (elig),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (issue)
    );

    assign req_ready = gnt;

    always_comb begin
        op_a   = '0;
        op_b   = '0;
        op_sub = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                op_a   = req_a[i*FP_W +: FP_W];
                op_b   = req_b[i*FP_W +: FP_W];
                op_sub = req_sub[i];
            end
        end
    end

`ifdef FPA_SUB_EN
    assign op_b_eff = {op_b[FP_W-1] ^ op_sub, op_b[FP_W-2:0]};
`else
    logic unused_sub;
    assign unused_sub = op_sub;
    assign op_b_eff   = op_b;
`endif

    assign tag_in.valid = issue;
    assign tag_in.id    = TAG_ID_W'(gnt_idx);
    assign tag_out      = tag_q[FPA_LAT];

    always_comb begin
        done_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            done_oh[i] = tag_out.valid && (tag_out.id == TAG_ID_W'(i));
        end
    end

    // Issue and completion never hit the same requester: issue needs pending clear.
    assign pending_d = (pending_q & ~done_oh) | (issue ? gnt : '0);

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < NSTG; s++) begin
            busy = busy | tag_q[s].valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            ptr_q     <= '0;
            fpa_a     <= '0;
            fpa_b     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int s = 0; s < NSTG; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            if (issue) begin
                fpa_a <= op_a;
                fpa_b <= op_b_eff;
            end
            rsp_valid <= done_oh;
            if (tag_out.valid) begin
                rsp_data <= fpa_c;
            end
            tag_q[0] <= tag_in;
            for (int s = 1; s < NSTG; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

endmodule

// File: tb/tb_fpa_sched.sv
// Directed bench for fpa_sched with a fixed-latency stand-in adder.
module tb_fpa_sched;

    import fpa_sched_pkg::*;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned FPA_LAT = 2;
    localparam int unsigned W       = 32;

    localparam logic [31:0] OPS_A [4] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000,
                                          32'h0000_4000};
    localparam logic [31:0] OPS_B [4] = '{32'h0000_0000, 32'h0000_0010, 32'h0000_0020,
                                          32'h0000_0030};
    localparam logic [31:0] EXP_C [4] = '{32'h0000_1000, 32'h0000_2010, 32'h0000_3020,
                                          32'h0000_4030};

`ifdef FPA_SUB_EN
    localparam logic [31:0] SUB_B = 32'hBF10_0000;
    localparam logic [31:0] SUB_C = 32'h3F20_0000;
`else
    localparam logic [31:0] SUB_B = 32'h3F10_0000;
    localparam logic [31:0] SUB_C = 32'h3FE0_0000;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic [W-1:0]      fpa_a;
    logic [W-1:0]      fpa_b;
    logic [W-1:0]      fpa_c;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fpa_sched #(
        .NREQ    (NREQ),
        .FPA_LAT (FPA_LAT),
        .FP_W    (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .fpa_a     (fpa_a),
        .fpa_b     (fpa_b),
        .fpa_c     (fpa_c),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Known single-precision cases; other operands get an integer sum that tags the op.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F98_0000 && b == 32'h3F10_0000) return 32'h3FE0_0000;
        if (a == 32'h3F98_0000 && b == 32'hBF10_0000) return 32'h3F20_0000;
        if (a == FP_ONE && b == FP_ZERO) return FP_ONE;
        return a + b;
    endfunction

    logic [W-1:0] fpa_pipe [FPA_LAT];
    always @(posedge clk) begin
        fpa_pipe[0] <= fadd(fpa_a, fpa_b);
        for (int k = 1; k < FPA_LAT; k++) fpa_pipe[k] <= fpa_pipe[k-1];
    end
    assign fpa_c = fpa_pipe[FPA_LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic sub);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_sub[i]      = sub;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        repeat (3) tick();
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_fpa_a", fpa_a, 32'h0);
        check("reset_fpa_b", fpa_b, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single add from requester 0.
        set_op(0, 32'h3F98_0000, 32'h3F10_0000, 1'b0);
        req_valid = 4'b0001;
        #1 check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("single_fpa_a", fpa_a, 32'h3F98_0000);
        check("single_fpa_b", fpa_b, 32'h3F10_0000);
        check("single_busy", 32'(busy), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("single_rsp_valid", 32'(rsp_valid), (k == 3) ? 32'h1 : 32'h0);
        end
        check("single_rsp_data", rsp_data, 32'h3FE0_0000);
        tick();
        check("single_rsp_clear", 32'(rsp_valid), 32'h0);
        check("single_rsp_hold", rsp_data, 32'h3FE0_0000);
        check("single_idle", 32'(busy), 32'h0);

        // Same operands with subtract select; pointer is at 1, so this also wraps.
        set_op(0, 32'h3F98_0000, 32'h3F10_0000, 1'b1);
        req_valid = 4'b0001;
        #1 check("sub_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("sub_fpa_b", fpa_b, SUB_B);
        repeat (3) tick();
        check("sub_rsp_valid", 32'(rsp_valid), 32'h1);
        check("sub_rsp_data", rsp_data, SUB_C);
        req_sub = '0;
        tick();

        // All four valid from reset: round-robin order and back-to-back responses.
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, OPS_A[i], OPS_B[i], 1'b0);
        req_valid = 4'hF;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                #1 check("rr_ready", 32'(req_ready), 32'(1 << k));
            end
            tick();
            if (k < 4) begin
                req_valid[k] = 1'b0;
                check("rr_fpa_a", fpa_a, OPS_A[k]);
            end
            check("rr_busy", 32'(busy), 32'(k <= 5));
            check("rr_rsp_valid", 32'(rsp_valid), (k >= 3) ? 32'(1 << (k - 3)) : 32'h0);
            if (k >= 3) check("rr_rsp_data", rsp_data, EXP_C[k-3]);
        end

        // Requester 2 holds valid: blocked while pending, regranted in its strobe cycle.
        set_op(2, FP_ONE, FP_ZERO, 1'b0);
        req_valid = 4'b0100;
        #1 check("pend_ready0", 32'(req_ready), 32'h4);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("pend_ready", 32'(req_ready), (k == 3 || k == 7) ? 32'h4 : 32'h0);
            check("pend_rsp_valid", 32'(rsp_valid), (k == 3 || k == 7) ? 32'h4 : 32'h0);
            if (k == 3 || k == 7) check("pend_rsp_data", rsp_data, FP_ONE);
        end
        req_valid = '0;

        // Pointer is at 3: grant 3, then with 0 and 3 both valid, 0 goes first.
        set_op(3, OPS_A[3], OPS_B[3], 1'b0);
        set_op(0, OPS_A[0], OPS_B[0], 1'b0);
        req_valid = 4'b1000;
        #1 check("wrap_ready3", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        repeat (3) tick();
        check("wrap_rsp3", 32'(rsp_valid), 32'h8);
        check("wrap_data3", rsp_data, EXP_C[3]);
        req_valid = 4'b1001;
        #1 check("wrap_ready0", 32'(req_ready), 32'h1);
        tick();
        check("wrap_fpa_a", fpa_a, OPS_A[0]);
        check("wrap_next", 32'(req_ready), 32'h8);
        req_valid = '0;
        repeat (3) tick();
        check("wrap_rsp0", 32'(rsp_valid), 32'h1);
        check("wrap_data0", rsp_data, EXP_C[0]);

        // Reset one cycle after issuing to requester 1: the op must vanish.
        set_op(1, OPS_A[1], OPS_B[1], 1'b0);
        req_valid = 4'b0010;
        #1 check("mid_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rsp_data", rsp_data, 32'h0);
        check("mid_fpa_a", fpa_a, 32'h0);
        check("mid_fpa_b", fpa_b, 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_req_ready", 32'(req_ready), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mid_no_rsp", 32'(rsp_valid), 32'h0);
            check("mid_no_busy", 32'(busy), 32'h0);
        end
        req_valid = 4'hF;
        #1 check("mid_first_grant", 32'(req_ready), 32'h1);
        req_valid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpa_sched.md
Name: fpa_sched

Overview:
- Shares one single-precision floating-point adder (fpa: a, b in; c out) between NREQ requesters.
- Round-robin arbiter: at most one new operation issued per cycle.
- A tag pipeline tracks in-flight operations and routes each sum back to its requester.
- Sits between the vector/control units and the fpa instance; the fpa has no handshake of its own.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FPA_LAT, 2, cycles from fpa a/b changing to fpa c being valid (1..8).
- FP_W, 32, operand width (IEEE-754 single).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  grant/accept; a transfer occurs when valid and ready are both high at the clock edge.
- req_a  in  NREQ*FP_W  operand A; requester i uses slice i.
- req_b  in  NREQ*FP_W  operand B; requester i uses slice i.
- req_sub  in  NREQ  subtract select; used only with FPA_SUB_EN.
- fpa_a  out  FP_W  registered operand to the adder.
- fpa_b  out  FP_W  registered operand to the adder.
- fpa_c  in  FP_W  adder result.
- rsp_valid  out  NREQ  one-hot, one-cycle result strobe.
- rsp_data  out  FP_W  result, valid when any rsp_valid bit is high.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Reset (async assert, sync release):
  - req_ready, rsp_valid, rsp_data, fpa_a, fpa_b = 0; busy = 0.
  - RR pointer = 0; pending bits = 0; tag pipeline cleared.
- Eligibility: requester i is eligible when req_valid[i] = 1 and pending[i] = 0. Each requester has at most one outstanding operation.
- Arbitration (combinational):
  - Scan from RR pointer upward, wrapping modulo NREQ; first eligible requester wins.
  - req_ready is one-hot on the winner, all zero if none eligible.
  - req_ready never asserts for a requester that is not eligible.
- Issue at edge T (handshake on requester g):
  - fpa_a, fpa_b <= req_a[g], req_b[g]; pending[g] <= 1; RR pointer <= (g+1) mod NREQ.
  - Tag {valid = 1, id = g} enters stage 0 of a FPA_LAT+1 deep shift register.
- Idle cycles: fpa_a/fpa_b hold their last values; a tag with valid = 0 is shifted in; the pointer does not move.
- Completion at edge T+1+FPA_LAT (tag reaches last stage):
  - rsp_data <= fpa_c; rsp_valid[id] <= 1 for exactly one cycle; pending[id] <= 0.
  - Result latency: rsp visible T+1+FPA_LAT cycles after the issue edge.
  - Throughput: one op per cycle across requesters.
- Responses have no backpressure; requesters must sample rsp_data in the strobe cycle.
- rsp_data holds its value when no strobe is active.
- Same-cycle boundary: in the cycle rsp_valid[i] is high, pending[i] is already clear, so requester i may be granted in that same cycle.
- Arbitration and completion for different requesters in one cycle are independent.
- busy = OR of tag-pipeline valid bits.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid is produced for them.
- A requester that drops req_valid before grant is simply skipped; no ordering state is kept.

Optional Feature:
- Macro FPA_SUB_EN.
- Defined: on issue, fpa_b <= {req_b[g][31] ^ req_sub[g], req_b[g][30:0]}, so the operation is A−B when req_sub = 1.
- Undefined: req_sub is ignored (port kept, unused); fpa_b = req_b[g] unchanged.

Decomposition:
- Package fpa_sched_pkg holds:
  - FP_W = 32, SIGN_BIT = 31.
  - Tag typedef: struct {logic valid; logic [$clog2(NREQ)-1:0] id}.
  - Canned constants FP_ONE = 32'h3F800000 and FP_ZERO.
- One sub-module, rr_arbiter: request vector + pointer in, one-hot grant + encoded index out.
- Tag pipeline and pending bits stay in fpa_sched.

Test Plan:
- Single op: req 0 issues a = 32'h3F980000 (1.1875), b = 32'h3F100000 (0.5625) -> rsp_valid = 4'b0001 exactly FPA_LAT+1 cycles after the handshake, rsp_data = 32'h3FE00000 (1.75).
- All four requesters valid from reset -> grants in order 0, 1, 2, 3 on consecutive edges; responses in the same order on consecutive cycles; busy high throughout.
- Pending block: req 2 holds req_valid high continuously -> its req_ready stays low until the cycle its rsp_valid[2] pulses, then it is regranted; no second grant while outstanding.
- Wrap and fairness: after a grant to 3, with 0 and 3 both valid -> grant to 0 first.
- Reset mid-flight: drop rst_n one cycle after issuing to requester 1 -> no rsp_valid ever appears; all outputs 0; first post-reset grant goes to requester 0.
- FPA_SUB_EN defined, req_sub = 1 with the operands of the single-op test -> rsp_data = 32'h3F200000 (0.625). Macro undefined, same stimulus -> 32'h3FE00000.
